// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-keyboard command sequencer: inhibit/RTS handshake, bit shifting on
// keyboard clock edges, line-ack check, and FA/FE reply handling with resend.
module ps2_host_cmd_ctrl #(
    parameter int unsigned INHIBIT_CYC     = 10000,
    parameter int unsigned BIT_TIMEOUT_CYC = 200000,
    parameter int unsigned ACK_TIMEOUT_CYC = 2000000,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       ps2_c_in,
    input  logic       ps2_d_in,
    output logic       ps2_c_oe,
    output logic       ps2_d_oe,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] arg_byte,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [3:0] StIdle      = 4'd0;
    localparam logic [3:0] StInhibit   = 4'd1;
    localparam logic [3:0] StRts       = 4'd2;
    localparam logic [3:0] StTx        = 4'd3;
    localparam logic [3:0] StLack      = 4'd4;
    localparam logic [3:0] StWaitClkHi = 4'd5;
    localparam logic [3:0] StReply     = 4'd6;
    localparam logic [3:0] StDone      = 4'd7;
    localparam logic [3:0] StErr       = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [31:0]   timer_q, timer_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    arg_q, arg_d;
    logic          has_arg_q, has_arg_d;
    logic          first_q, first_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          c_oe_q, c_oe_d;
    logic          d_oe_q, d_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, err_q;

    logic [3:0] c_sh_q, d_sh_q;
    logic       c_filt_q, c_filt_d;
    logic       d_filt_q, d_filt_d;
    logic       c_prev_q;
    logic       c_fall;

    // Glitch filter doubles as the pad synchroniser; value only moves on 4 agreeing samples.
    always_comb begin
        c_filt_d = c_filt_q;
        if (c_sh_q == 4'hF) c_filt_d = 1'b1;
        else if (c_sh_q == 4'h0) c_filt_d = 1'b0;
        d_filt_d = d_filt_q;
        if (d_sh_q == 4'hF) d_filt_d = 1'b1;
        else if (d_sh_q == 4'h0) d_filt_d = 1'b0;
    end

    assign c_fall = c_prev_q & ~c_filt_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 32'd1;
        bit_idx_d  = bit_idx_q;
        byte_d     = byte_q;
        arg_d      = arg_q;
        has_arg_d  = has_arg_q;
        first_d    = first_q;
        retry_d    = retry_q;
        err_code_d = err_code_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d    = StInhibit;
                    byte_d     = cmd_byte;
                    arg_d      = arg_byte;
                    has_arg_d  = cmd_has_arg;
                    first_d    = 1'b1;
                    retry_d    = '0;
                    err_code_d = 2'b00;
                end
            end
            StInhibit: begin
                if (timer_q == INHIBIT_CYC - 1) state_d = StRts;
            end
            StRts: begin
                state_d   = StTx;
                bit_idx_d = 4'd0;
            end
            StTx: begin
                if (c_fall) begin
                    timer_d   = '0;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd9) state_d = StLack;
                end else if (timer_q == BIT_TIMEOUT_CYC - 1) begin
                    state_d    = StErr;
                    err_code_d = 2'b01;
                end
            end
            StLack: begin
                if (c_fall) begin
                    if (!d_filt_q) begin
                        state_d = StWaitClkHi;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 2'b10;
                    end
                end else if (timer_q == BIT_TIMEOUT_CYC - 1) begin
                    state_d    = StErr;
                    err_code_d = 2'b01;
                end
            end
            StWaitClkHi: begin
                if (c_filt_q) state_d = StReply;
            end
            StReply: begin
                if (rx_valid && rx_data == 8'hFA) begin
                    if (first_q && has_arg_q) begin
                        byte_d  = arg_q;
                        first_d = 1'b0;
                        retry_d = '0;
                        state_d = StInhibit;
                    end else begin
                        state_d = StDone;
                    end
                end else if (rx_valid && rx_data == 8'hFE) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = StInhibit;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 2'b11;
                    end
                end else if (timer_q == ACK_TIMEOUT_CYC - 1) begin
                    state_d    = StErr;
                    err_code_d = 2'b11;
                end
            end
            StDone, StErr: state_d = StIdle;
            default:       state_d = StIdle;
        endcase
        // Every state's timer counts from its own entry.
        if (state_d != state_q) timer_d = '0;
    end

    // Pad drives are registered from next state so they never glitch.
    always_comb begin
        c_oe_d = (state_d == StInhibit) || (state_d == StRts);
        d_oe_d = 1'b0;
        if (state_d == StRts) begin
            d_oe_d = 1'b1;
        end else if (state_d == StTx) begin
            if (state_q != StTx) d_oe_d = 1'b1;
            else if (c_fall) d_oe_d = (bit_idx_q < 4'd8) ? ~byte_q[bit_idx_q[2:0]] : ^byte_q;
            else d_oe_d = d_oe_q;
        end
        busy_d = !(state_d inside {StIdle, StDone, StErr});
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_q     <= '0;
            arg_q      <= '0;
            has_arg_q  <= 1'b0;
            first_q    <= 1'b0;
            retry_q    <= '0;
            err_code_q <= 2'b00;
            c_oe_q     <= 1'b0;
            d_oe_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            c_sh_q     <= 4'hF;
            d_sh_q     <= 4'hF;
            c_filt_q   <= 1'b1;
            d_filt_q   <= 1'b1;
            c_prev_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_q     <= byte_d;
            arg_q      <= arg_d;
            has_arg_q  <= has_arg_d;
            first_q    <= first_d;
            retry_q    <= retry_d;
            err_code_q <= err_code_d;
            c_oe_q     <= c_oe_d;
            d_oe_q     <= d_oe_d;
            busy_q     <= busy_d;
            done_q     <= (state_d == StDone);
            err_q      <= (state_d == StErr);
            c_sh_q     <= {c_sh_q[2:0], ps2_c_in};
            d_sh_q     <= {d_sh_q[2:0], ps2_d_in};
            c_filt_q   <= c_filt_d;
            d_filt_q   <= d_filt_d;
            c_prev_q   <= c_filt_q;
        end
    end

    assign ps2_c_oe  = c_oe_q;
    assign ps2_d_oe  = d_oe_q;
    assign cmd_ready = (state_q == StIdle);
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
